// File: rtl/serial_fullsub_if.sv
// serial_fullsub_if: start/busy/done handshake and operand/result bus for the bit-serial subtractor
interface serial_fullsub_if #(parameter int WIDTH = 4);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             b_out;
    modport master (output start, a, b, b_in, input busy, done, diff, b_out);
    modport slave  (input start, a, b, b_in, output busy, done, diff, b_out);
endinterface

// File: rtl/serial_fullsub.sv
// serial_fullsub: bit-serial ripple-borrow subtractor, one full-subtractor cell, LSB first
module serial_fullsub #(
    parameter int WIDTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    serial_fullsub_if.slave s
);
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t           state, state_n;
    logic [WIDTH-1:0] a_sr, b_sr, w;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic             d, nb, accept, last;
    always_comb begin
        d       = a_sr[0] ^ b_sr[0] ^ borrow;
        nb      = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & borrow);
        accept  = s.start && state != SHIFT;
        last    = state == SHIFT && cnt == CW'(WIDTH - 1);
        state_n = accept ? SHIFT : last ? DONE : state == DONE ? IDLE : state;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            a_sr    <= '0;
            b_sr    <= '0;
            w       <= '0;
            borrow  <= 1'b0;
            cnt     <= '0;
            s.busy  <= 1'b0;
            s.done  <= 1'b0;
            s.diff  <= '0;
            s.b_out <= 1'b0;
        end else begin
            state  <= state_n;
            s.busy <= accept || (state == SHIFT && !last);
            s.done <= last;
            if (accept) begin
                a_sr   <= s.a;
                b_sr   <= s.b;
                borrow <= s.b_in;
                cnt    <= '0;
            end else if (state == SHIFT) begin
                a_sr   <= a_sr >> 1;
                b_sr   <= b_sr >> 1;
                borrow <= nb;
                w      <= {d, w[WIDTH-1:1]};
                cnt    <= cnt + CW'(1);
            end
            // results only move on the completing edge so partial sums never leak out
            if (last) begin
                s.diff  <= {d, w[WIDTH-1:1]};
                s.b_out <= nb;
            end
        end
    end
endmodule
